// File: rtl/h_pair_sequencer_pkg.sv
// Shared types and helpers for the Hadamard pair sequencer and its tag delay line.
package h_pair_sequencer_pkg;

  localparam int AMP_DATA_W = 8;  // S3.4 amplitude component width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // Spread pair number p around bit position t, leaving a 0 there: gives the low index of the pair.
  function automatic logic [31:0] insert_zero_bit(input logic [31:0] p, input logic [31:0] t);
    logic [31:0] low_mask;
    low_mask = (32'd1 << t) - 32'd1;
    return ((p & ~low_mask) << 1) | (p & low_mask);
  endfunction

endpackage

// File: rtl/h_pair_sequencer_tag_delay.sv
// Tag delay line for h_pair_sequencer: carries {valid, lo, hi} alongside the h_gate pipeline.
module h_tag_delay #(
  parameter int DEPTH = 2,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic [AW-1:0] push_lo,
  input  logic [AW-1:0] push_hi,
  output logic          tail_vld,
  output logic [AW-1:0] tail_lo,
  output logic [AW-1:0] tail_hi,
  output logic          pending
);

  logic [DEPTH-1:0] vld_r;
  logic [AW-1:0]    lo_r [DEPTH];
  logic [AW-1:0]    hi_r [DEPTH];

  // Shift register of pair tags; clr flushes synchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        lo_r[k] <= '0;
        hi_r[k] <= '0;
      end
    end else if (clr) begin
      vld_r <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        lo_r[k] <= '0;
        hi_r[k] <= '0;
      end
    end else begin
      vld_r[0] <= push;
      lo_r[0]  <= push_lo;
      hi_r[0]  <= push_hi;
      for (int k = 1; k < DEPTH; k++) begin
        vld_r[k] <= vld_r[k-1];
        lo_r[k]  <= lo_r[k-1];
        hi_r[k]  <= hi_r[k-1];
      end
    end
  end

  assign tail_vld = vld_r[DEPTH-1];
  assign tail_lo  = lo_r[DEPTH-1];
  assign tail_hi  = hi_r[DEPTH-1];

  // Entries still in flight after this cycle's tail retires.
  always_comb begin
    pending = 1'b0;
    for (int k = 0; k < DEPTH - 1; k++) begin
      pending = pending | vld_r[k];
    end
  end

endmodule

// File: rtl/h_pair_sequencer.sv
// Hadamard pass sequencer: holds the amplitude vector, streams disjoint pairs
// into h_gate and writes the results back in place as they emerge.
module h_pair_sequencer
  import h_pair_sequencer_pkg::*;
#(
  parameter int NUM_QUBITS = 3,
  parameter int DATA_W     = AMP_DATA_W,
  parameter int H_LATENCY  = 2,
  localparam int TW        = (NUM_QUBITS > 1) ? $clog2(NUM_QUBITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [TW-1:0]         target,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic                  ld_en,
  input  logic [NUM_QUBITS-1:0] ld_addr,
  input  logic [DATA_W-1:0]     ld_r,
  input  logic [DATA_W-1:0]     ld_i,
  input  logic [NUM_QUBITS-1:0] rd_addr,
  output logic [DATA_W-1:0]     rd_r,
  output logic [DATA_W-1:0]     rd_i,
  output logic [DATA_W-1:0]     ha_r,
  output logic [DATA_W-1:0]     ha_i,
  output logic [DATA_W-1:0]     hb_r,
  output logic [DATA_W-1:0]     hb_i,
  input  logic [DATA_W-1:0]     hn_ar,
  input  logic [DATA_W-1:0]     hn_ai,
  input  logic [DATA_W-1:0]     hn_br,
  input  logic [DATA_W-1:0]     hn_bi
);

  localparam int                    DEPTH    = 1 << NUM_QUBITS;
  localparam int                    PAIRS    = 1 << (NUM_QUBITS - 1);
  localparam logic [NUM_QUBITS-1:0] P_LAST   = NUM_QUBITS'(PAIRS - 1);
  localparam logic [TW:0]           NQ_LIMIT = (TW + 1)'(NUM_QUBITS);

  seq_state_e            state_r, state_s;
  logic [TW-1:0]         tgt_r, tgt_s;
  logic [NUM_QUBITS-1:0] p_r, p_s;
  logic                  push_s, err_s, ld_ok_s, flush_s;
  logic [NUM_QUBITS-1:0] lo_nx_s, hi_nx_s;
  logic [NUM_QUBITS-1:0] iss_lo_r, iss_hi_r;
  logic                  tail_vld_s, pending_s;
  logic [NUM_QUBITS-1:0] tail_lo_s, tail_hi_s;
  logic [DATA_W-1:0]     amp_re_r [DEPTH];
  logic [DATA_W-1:0]     amp_im_r [DEPTH];

  // Pair indices for the cycle being entered; ha/hb are registered one edge ahead.
  assign lo_nx_s = NUM_QUBITS'(insert_zero_bit(32'(p_s), 32'(tgt_s)));
  assign hi_nx_s = lo_nx_s | (NUM_QUBITS'(1'b1) << tgt_s);
  assign ld_ok_s = ld_en & (state_r == ST_IDLE);
  assign flush_s = (state_r == ST_IDLE);

  h_tag_delay #(
    .DEPTH (H_LATENCY),
    .AW    (NUM_QUBITS)
  ) u_tag_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (flush_s),
    .push     (push_s),
    .push_lo  (iss_lo_r),
    .push_hi  (iss_hi_r),
    .tail_vld (tail_vld_s),
    .tail_lo  (tail_lo_s),
    .tail_hi  (tail_hi_s),
    .pending  (pending_s)
  );

  // Next-state logic; DONE accepts a start exactly like IDLE so passes can chain.
  always_comb begin
    state_s = state_r;
    tgt_s   = tgt_r;
    p_s     = p_r;
    push_s  = 1'b0;
    err_s   = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if ({1'b0, target} < NQ_LIMIT) begin
            tgt_s   = target;
            p_s     = '0;
            state_s = ST_ISSUE;
          end else begin
            err_s   = 1'b1;
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        push_s = 1'b1;
        p_s    = p_r + NUM_QUBITS'(1'b1);
        if (p_r == P_LAST) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        // The tail retires this cycle, so only the earlier stages matter.
        if (pending_s) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM state, latched target and pair counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      tgt_r   <= '0;
      p_r     <= '0;
    end else begin
      state_r <= state_s;
      tgt_r   <= tgt_s;
      p_r     <= p_s;
    end
  end

  // Registered status pulses and the h_gate operand bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      ha_r     <= '0;
      ha_i     <= '0;
      hb_r     <= '0;
      hb_i     <= '0;
      iss_lo_r <= '0;
      iss_hi_r <= '0;
    end else begin
      busy <= (state_s == ST_ISSUE) || (state_s == ST_DRAIN);
      done <= (state_s == ST_DONE);
      err  <= err_s;
      if (state_s == ST_ISSUE) begin
        ha_r     <= amp_re_r[lo_nx_s];
        ha_i     <= amp_im_r[lo_nx_s];
        hb_r     <= amp_re_r[hi_nx_s];
        hb_i     <= amp_im_r[hi_nx_s];
        iss_lo_r <= lo_nx_s;
        iss_hi_r <= hi_nx_s;
      end else begin
        ha_r     <= '0;
        ha_i     <= '0;
        hb_r     <= '0;
        hb_i     <= '0;
        iss_lo_r <= '0;
        iss_hi_r <= '0;
      end
    end
  end

  // Amplitude storage: host loads only in IDLE, h_gate results land when the tag tail is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        amp_re_r[k] <= '0;
        amp_im_r[k] <= '0;
      end
    end else if (ld_ok_s) begin
      amp_re_r[ld_addr] <= ld_r;
      amp_im_r[ld_addr] <= ld_i;
    end else if (tail_vld_s) begin
      amp_re_r[tail_lo_s] <= hn_ar;
      amp_im_r[tail_lo_s] <= hn_ai;
      amp_re_r[tail_hi_s] <= hn_br;
      amp_im_r[tail_hi_s] <= hn_bi;
    end
  end

  // Host read port, one cycle of latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_r <= '0;
      rd_i <= '0;
    end else begin
      rd_r <= amp_re_r[rd_addr];
      rd_i <= amp_im_r[rd_addr];
    end
  end

endmodule

// File: tb/tb_h_pair_sequencer.sv
// Randomised self-checking bench for h_pair_sequencer with a behavioural h_gate alongside.
module tb_h_pair_sequencer;

  localparam int NQ = 3;
  localparam int DW = 8;
  localparam int HL = 2;
  localparam int TW = 2;
  localparam int N  = 8;
  localparam int P  = 4;

  logic          clk = 1'b0;
  logic          rst_n, start, ld_en, busy, done, err;
  logic [TW-1:0] target;
  logic [NQ-1:0] ld_addr, rd_addr;
  logic [DW-1:0] ld_r, ld_i, rd_r, rd_i, ha_r, ha_i, hb_r, hb_i;
  logic [DW-1:0] hn_ar = '0, hn_ai = '0, hn_br = '0, hn_bi = '0;
  logic [DW-1:0] g1_ar = '0, g1_ai = '0, g1_br = '0, g1_bi = '0;

  int checks = 0;
  int errors = 0;
  int mre [N], mim [N], pre_re [N], pre_im [N];
  int rec_har [40], rec_hai [40], rec_hbr [40], rec_hbi [40], rec_busy [40], rec_err [40];

  always #5 clk = ~clk;

  h_pair_sequencer #(.NUM_QUBITS(NQ), .DATA_W(DW), .H_LATENCY(HL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .target(target),
    .busy(busy), .done(done), .err(err),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_r(ld_r), .ld_i(ld_i),
    .rd_addr(rd_addr), .rd_r(rd_r), .rd_i(rd_i),
    .ha_r(ha_r), .ha_i(ha_i), .hb_r(hb_r), .hb_i(hb_i),
    .hn_ar(hn_ar), .hn_ai(hn_ai), .hn_br(hn_br), .hn_bi(hn_bi)
  );

  function automatic int s8(input logic [7:0] x);
    return int'($signed(x));
  endfunction

  // S3.4 multiply by 1/sqrt(2) (= 11/16), truncating, wrapped to 8 bits.
  function automatic int hmul(input int s);
    int v;
    v = (s * 32'sd11) >>> 4;
    return int'($signed(v[7:0]));
  endfunction

  // h_gate stand-in: two register stages.
  always @(posedge clk) begin
    g1_ar <= DW'(hmul(s8(ha_r) + s8(hb_r)));
    g1_ai <= DW'(hmul(s8(ha_i) + s8(hb_i)));
    g1_br <= DW'(hmul(s8(ha_r) - s8(hb_r)));
    g1_bi <= DW'(hmul(s8(ha_i) - s8(hb_i)));
    hn_ar <= g1_ar;
    hn_ai <= g1_ai;
    hn_br <= g1_br;
    hn_bi <= g1_bi;
  end

  function automatic void model_pass(input int t);
    int j, a, b;
    for (int i = 0; i < N; i++) begin
      if (((i >> t) & 1) == 0) begin
        j = i | (1 << t);
        a = mre[i]; b = mre[j]; mre[i] = hmul(a + b); mre[j] = hmul(a - b);
        a = mim[i]; b = mim[j]; mim[i] = hmul(a + b); mim[j] = hmul(a - b);
      end
    end
  endfunction

  function automatic int issue_index(input int t, input int j);
    int n = 0;
    for (int i = 0; i < N; i++) begin
      if (((i >> t) & 1) == 0) begin
        if (n == j) return i;
        n++;
      end
    end
    return -1;
  endfunction

  function automatic void snapshot();
    for (int a = 0; a < N; a++) begin
      pre_re[a] = mre[a];
      pre_im[a] = mim[a];
    end
  endfunction

  task automatic load(input int a, input int r, input int i);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = NQ'(a); ld_r = DW'(r); ld_i = DW'(i);
    @(negedge clk);
    ld_en = 1'b0;
    mre[a] = r;
    mim[a] = i;
  endtask

  task automatic rd(input int a, output int r, output int i);
    @(negedge clk);
    rd_addr = NQ'(a);
    @(negedge clk);
    r = s8(rd_r);
    i = s8(rd_i);
  endtask

  // Caller is at a negedge: that cycle is cycle 0 of the pass.
  task automatic run_pass(input int tgt, input bit chain, input int nxt, input bit disturb, output int dcyc);
    start = 1'b1; target = TW'(tgt); dcyc = -1;
    for (int k = 1; k < 40 && dcyc < 0; k++) begin
      @(negedge clk);
      start = 1'b0; ld_en = 1'b0;
      rec_har[k] = s8(ha_r); rec_hai[k] = s8(ha_i); rec_hbr[k] = s8(hb_r); rec_hbi[k] = s8(hb_i);
      rec_busy[k] = busy ? 1 : 0;
      rec_err[k]  = err ? 1 : 0;
      if (done) begin
        dcyc = k;
        if (chain) begin
          start = 1'b1; target = TW'(nxt);
        end
      end else if (disturb && k == 2) begin
        start = 1'b1; target = TW'((tgt + 1) % NQ);
        ld_en = 1'b1; ld_addr = '0; ld_r = 8'd99; ld_i = 8'd99;
      end
    end
    if (dcyc > 0) model_pass(tgt);
  endtask

  task automatic test_reset();
    int r, i;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset_status: got %b expected 000", {busy, done, err}); end
    checks++;
    if ({ha_r, ha_i, hb_r, hb_i} !== 32'h0) begin errors++; $display("FAIL reset_hbus: got %h expected 0", {ha_r, ha_i, hb_r, hb_i}); end
    rst_n = 1'b1;
    for (int a = 0; a < N; a++) begin
      rd(a, r, i);
      checks++;
      if (r !== 0 || i !== 0) begin errors++; $display("FAIL reset_amp[%0d]: got %0d,%0d expected 0,0", a, r, i); end
    end
  endtask

  task automatic test_single_qubit();
    int d, r, i;
    load(0, 16, 0);
    run_pass(0, 1'b0, 0, 1'b0, d);
    checks++;
    if (d !== 7) begin errors++; $display("FAIL single_done_cycle: got %0d expected 7", d); end
    for (int k = 1; k <= 7; k++) begin
      checks++;
      if (rec_busy[k] !== ((k < 7) ? 1 : 0)) begin errors++; $display("FAIL single_busy[%0d]: got %0d expected %0d", k, rec_busy[k], (k < 7) ? 1 : 0); end
    end
    for (int a = 0; a < N; a++) begin
      rd(a, r, i);
      checks++;
      if (r !== ((a < 2) ? 11 : 0) || i !== 0) begin errors++; $display("FAIL single_amp[%0d]: got %0d,%0d expected %0d,0", a, r, i, (a < 2) ? 11 : 0); end
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2, r, i;
    load(0, 16, 0);
    load(1, 0, 0);
    run_pass(0, 1'b1, 1, 1'b0, d1);
    run_pass(1, 1'b0, 0, 1'b0, d2);
    checks++;
    if (d1 !== 7) begin errors++; $display("FAIL b2b_first_done: got %0d expected 7", d1); end
    checks++;
    if (d2 !== 7) begin errors++; $display("FAIL b2b_second_done: got %0d expected 7", d2); end
    for (int a = 0; a < N; a++) begin
      rd(a, r, i);
      checks++;
      if (r !== ((a < 4) ? 7 : 0) || i !== 0) begin errors++; $display("FAIL b2b_amp[%0d]: got %0d,%0d expected %0d,0", a, r, i, (a < 4) ? 7 : 0); end
    end
  endtask

  task automatic test_pairing_order();
    int d, lo, ea, eb;
    for (int a = 0; a < N; a++) load(a, a + 1, 0);
    snapshot();
    checks++;
    if ({ha_r, hb_r} !== 16'h0) begin errors++; $display("FAIL pair_idle_hbus: got %h expected 0", {ha_r, hb_r}); end
    run_pass(2, 1'b0, 0, 1'b0, d);
    checks++;
    if (d !== 7) begin errors++; $display("FAIL pair_done_cycle: got %0d expected 7", d); end
    for (int k = 1; k <= 7; k++) begin
      lo = issue_index(2, k - 1);
      ea = (k <= P) ? pre_re[lo] : 0;
      eb = (k <= P) ? pre_re[lo | 4] : 0;
      checks++;
      if (rec_har[k] !== ea || rec_hbr[k] !== eb) begin errors++; $display("FAIL pair_order[%0d]: got (%0d,%0d) expected (%0d,%0d)", k, rec_har[k], rec_hbr[k], ea, eb); end
    end
  endtask

  task automatic test_illegal_target();
    int r, i;
    snapshot();
    start = 1'b1; target = 2'd3;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL illegal_pulse: got err=%b busy=%b expected err=1 busy=0", err, busy); end
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL illegal_after: got err=%b busy=%b expected 0 0", err, busy); end
    for (int a = 0; a < N; a++) begin
      rd(a, r, i);
      checks++;
      if (r !== pre_re[a] || i !== pre_im[a]) begin errors++; $display("FAIL illegal_amp[%0d]: got %0d,%0d expected %0d,%0d", a, r, i, pre_re[a], pre_im[a]); end
    end
  endtask

  task automatic test_random_passes();
    int d, lo, r, i;
    for (int rep = 0; rep < 3; rep++) begin
      for (int a = 0; a < N; a++) load(a, $urandom_range(0, 127) - 64, $urandom_range(0, 127) - 64);
      snapshot();
      run_pass(rep, 1'b0, 0, 1'b0, d);
      checks++;
      if (d !== 7) begin errors++; $display("FAIL rand_done[%0d]: got %0d expected 7", rep, d); end
      for (int k = 1; k <= P; k++) begin
        lo = issue_index(rep, k - 1);
        checks++;
        if (rec_har[k] !== pre_re[lo] || rec_hai[k] !== pre_im[lo] ||
            rec_hbr[k] !== pre_re[lo | (1 << rep)] || rec_hbi[k] !== pre_im[lo | (1 << rep)]) begin
          errors++;
          $display("FAIL rand_issue[%0d][%0d]: got a=%0d,%0d b=%0d,%0d expected a=%0d,%0d b=%0d,%0d", rep, k,
                   rec_har[k], rec_hai[k], rec_hbr[k], rec_hbi[k], pre_re[lo], pre_im[lo],
                   pre_re[lo | (1 << rep)], pre_im[lo | (1 << rep)]);
        end
      end
      for (int a = 0; a < N; a++) begin
        rd(a, r, i);
        checks++;
        if (r !== mre[a] || i !== mim[a]) begin errors++; $display("FAIL rand_amp[%0d][%0d]: got %0d,%0d expected %0d,%0d", rep, a, r, i, mre[a], mim[a]); end
      end
    end
  endtask

  task automatic test_ignored_while_busy();
    int d, r, i, tgt;
    tgt = $urandom_range(0, NQ - 1);
    for (int a = 0; a < N; a++) load(a, $urandom_range(0, 127) - 64, $urandom_range(0, 127) - 64);
    run_pass(tgt, 1'b0, 0, 1'b1, d);
    checks++;
    if (d !== 7) begin errors++; $display("FAIL busy_ign_done: got %0d expected 7", d); end
    for (int k = 1; k <= 7; k++) begin
      checks++;
      if (rec_err[k] !== 0) begin errors++; $display("FAIL busy_ign_err[%0d]: got %0d expected 0", k, rec_err[k]); end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_ign_restart: got busy=%b expected 0", busy); end
    for (int a = 0; a < N; a++) begin
      rd(a, r, i);
      checks++;
      if (r !== mre[a] || i !== mim[a]) begin errors++; $display("FAIL busy_ign_amp[%0d]: got %0d,%0d expected %0d,%0d", a, r, i, mre[a], mim[a]); end
    end
  endtask

  task automatic test_reset_mid_pass();
    int d, r, i;
    for (int a = 0; a < N; a++) load(a, a + 1, -a);
    start = 1'b1; target = 2'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL midrst_status: got %b expected 000", {busy, done, err}); end
    checks++;
    if ({ha_r, ha_i, hb_r, hb_i} !== 32'h0) begin errors++; $display("FAIL midrst_hbus: got %h expected 0", {ha_r, ha_i, hb_r, hb_i}); end
    checks++;
    if ({rd_r, rd_i} !== 16'h0) begin errors++; $display("FAIL midrst_rd: got %h expected 0", {rd_r, rd_i}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < N; a++) begin
      mre[a] = 0;
      mim[a] = 0;
    end
    for (int a = 0; a < N; a++) begin
      rd(a, r, i);
      checks++;
      if (r !== 0 || i !== 0) begin errors++; $display("FAIL midrst_amp[%0d]: got %0d,%0d expected 0,0", a, r, i); end
    end
    load(0, 16, 0);
    run_pass(0, 1'b0, 0, 1'b0, d);
    checks++;
    if (d !== 7) begin errors++; $display("FAIL midrst_rerun_done: got %0d expected 7", d); end
    for (int a = 0; a < N; a++) begin
      rd(a, r, i);
      checks++;
      if (r !== mre[a] || i !== mim[a]) begin errors++; $display("FAIL midrst_rerun_amp[%0d]: got %0d,%0d expected %0d,%0d", a, r, i, mre[a], mim[a]); end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; target = '0; ld_en = 1'b0;
    ld_addr = '0; ld_r = '0; ld_i = '0; rd_addr = '0;
    for (int a = 0; a < N; a++) begin
      mre[a] = 0;
      mim[a] = 0;
    end
    test_reset();
    test_single_qubit();
    test_back_to_back();
    test_pairing_order();
    test_illegal_target();
    test_random_passes();
    test_ignored_while_busy();
    test_reset_mid_pass();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/h_pair_sequencer.md
Name: h_pair_sequencer

Overview:
- Drives the pipelined Hadamard stage for one target qubit at a time.
- Holds the full S3.4 complex state vector (2^NUM_QUBITS amplitudes).
- Streams amplitude pairs (i, i | 1<<target) into h_gate, one pair per cycle.
- Tracks h_gate latency with a tagged delay line and writes the results back in place.
- A host sequences QFT passes by pulsing start with successive targets.

Parameters:
- NUM_QUBITS, 3, qubit count; state vector depth = 2^NUM_QUBITS.
- DATA_W, `TOTAL_WIDTH (8), S3.4 amplitude component width.
- H_LATENCY, 2, cycles from h_gate input to valid h_gate output.
- TW (localparam), max(1, $clog2(NUM_QUBITS)), target index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pass request.
- target  in  TW  qubit index for the pass.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse when the pass completes.
- err  out  1  one-cycle pulse when start is rejected for an illegal target.
- ld_en  in  1  host write strobe.
- ld_addr  in  NUM_QUBITS  host write index.
- ld_r, ld_i  in  DATA_W each  host write amplitude.
- rd_addr  in  NUM_QUBITS  host read index.
- rd_r, rd_i  out  DATA_W each  amplitude at rd_addr, registered, 1-cycle latency.
- ha_r, ha_i, hb_r, hb_i  out  DATA_W each  alpha/beta to h_gate.
- hn_ar, hn_ai, hn_br, hn_bi  in  DATA_W each  new_alpha/new_beta from h_gate.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset state:
  - FSM = IDLE.
  - All outputs = 0.
  - All amplitude storage = 0.
  - Delay line valid bits = 0.
  - Pair counter = 0.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 with target < NUM_QUBITS: latch target, clear pair counter p, go to ISSUE. busy is high from the next cycle.
  - start=1 with target >= NUM_QUBITS: pulse err next cycle, stay in IDLE, no state change.
  - ld_en=1: write amp[ld_addr] <= {ld_r, ld_i}. Accepted only in IDLE; ignored in every other state.
- ISSUE (one cycle per pair, P = 2^(NUM_QUBITS-1) pairs):
  - lo = p with a 0 bit inserted at bit position target; hi = lo | (1<<target).
  - Drive ha = amp[lo], hb = amp[hi].
  - Push {valid=1, lo, hi} into an H_LATENCY-deep delay line; increment p.
  - After the P-th issue, go to DRAIN.
  - ha/hb are 0 in every cycle that is not ISSUE.
- Write-back:
  - When the delay-line tail is valid, amp[lo] <= hn_a and amp[hi] <= hn_b in the same cycle.
  - Pairs within a pass are disjoint, so there is no read/write hazard; no forwarding is needed.
- DRAIN: wait until every delay-line valid bit is 0, then go to DONE.
- DONE: done=1 for exactly one cycle, busy drops the same cycle, return to IDLE.
- Timing:
  - Start sampled in cycle 0; issues occupy cycles 1..P; last write-back at cycle P+H_LATENCY; done in cycle P+H_LATENCY+1.
  - Defaults: done in cycle 7.
  - Back-to-back: start may be asserted in the cycle done is high (the FSM is then IDLE-equivalent); the next pass begins the following cycle.
- Ignored requests: start while busy is ignored with no err. ld_en while busy is ignored.
- rd port:
  - Registered read of the current storage, usable at any time.
  - During a pass it returns in-flight (mixed old/new) values. The host must read only after done.
- Arithmetic: none in this block. Values pass through unmodified. Scaling, truncation and saturation belong to h_gate/ccmult; ccmult truncates.
- Reset mid-pass: everything returns to the reset state immediately. Storage is cleared, and no done or err is produced.

Decomposition:
- Shared package/header (alongside fixed_point_params.vh): DATA_W alias, state encoding localparams, pair-index insertion function (insert_zero_bit(p, target)).
- One natural sub-module: h_tag_delay, a parameterised shift register of {valid, lo, hi} with depth H_LATENCY and synchronous clear-on-reset.
- The bench instantiates h_pair_sequencer together with h_gate.

Test Plan:
- Single-qubit Hadamard:
  - Stimulus: load amp[0]=16 (1.0), others 0; start target=0.
  - Required: done at cycle 7; amp[0]=amp[1]=11 (r), all other components 0.
- Back-to-back passes:
  - Stimulus: after the previous test, start target=1 in the done cycle.
  - Required: second done 7 cycles later; amp[0..3]=7, amp[4..7]=0.
- Pairing order:
  - Stimulus: load amp[k].r = k+1; start target=2.
  - Required: (ha_r, hb_r) across issue cycles = (1,5),(2,6),(3,7),(4,8); ha/hb = 0 outside ISSUE.
- Illegal target:
  - Stimulus: start target=3.
  - Required: err pulse 1 cycle; busy stays 0; storage unchanged.
- Ignored requests while busy:
  - Stimulus: start and ld_en (addr 0, value 99) asserted in cycle 2 of a pass.
  - Required: both ignored; results identical to the undisturbed pass; no err.
- Reset mid-pass:
  - Stimulus: rst_n low at cycle 3 of a pass.
  - Required: busy, done, err and ha..hb drop to 0 immediately; all rd reads return 0; a new pass after release runs normally.
